multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath, replacing the single-cycle opcode decoder.
//  Sequences each instruction through FETCH/DECODE/execute/writeback.
//  Stalls on a memory ready handshake, with a parametrised timeout.
//  Drives the datapath mux selects and the enables for PC, IR, register file and memory.
// PARAMETERS
//  TIMEOUT  16  max cycles to wait for mem_ready in a memory state; 0 = wait forever
//  TO_W     5   wait counter width; must hold TIMEOUT
// PORTS
//  clk        in   1  clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  opcode     in   6  IR[31:26]; sampled in DECODE and MEMADR
//  mem_ready  in   1  memory has completed the current read/write this cycle
//  IorD       out  1  memory address select: 0=PC, 1=ALUOut
//  IRWrite    out  1  load instruction register
//  PCWrite    out  1  unconditional PC load
//  BranchOp   out  2  00 none, 01 beq (load PC if zero), 10 bne (load PC if !zero)
//  PCSource   out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
//  ALUSrcA    out  1  0=PC, 1=regA
//  ALUSrcB    out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALUOp      out  2  00 add, 01 sub, 10 funct-decoded
//  RegDst     out  1  0=rt, 1=rd
//  MemtoReg   out  1  0=ALUOut, 1=MDR
//  RegWrite   out  1  register file write enable
//  MemRead    out  1  memory read request; held until mem_ready
//  MemWrite   out  1  memory write request; held until mem_ready
//  bus_error  out  1  1-cycle pulse on memory timeout
//  illegal_op out  1  1-cycle pulse on unsupported opcode
//  state      out  4  current state code, for debug
// BEHAVIOUR
//  - All outputs decode from state; every output not listed for a state is 0.
//  - While reset=1: all outputs 0. Next state FETCH, wait counter 0. Applies mid-instruction; no write is completed.
//  FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
//    IRWrite=PCWrite=mem_ready (Mealy). On mem_ready -> DECODE, else stay.
//  DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00.
//    Opcode 000000 -> EXEC, 100011/101011 -> MEMADR, 000100/000101 -> BRANCH, 001000 -> ADDIEX.
//    Any other opcode -> FETCH with illegal_op=1 for one cycle.
//  MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
//  MEMRD (3): MemRead=1, IorD=1. On mem_ready -> MEMWB.
//  MEMWB (4): MemtoReg=1, RegWrite=1 -> FETCH.
//  MEMWR (5): MemWrite=1, IorD=1. On mem_ready -> FETCH.
//  EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
//  ALUWB (7): RegDst=1, RegWrite=1 -> FETCH.
//  BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01 -> FETCH.
//    BranchOp=01 for 000100, 10 for 000101; opcode latched in DECODE.
//  ADDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
//  ADDIWB (10): RegWrite=1, RegDst=0 -> FETCH.
//  Cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, branch 3.
//  Wait counter:
//    - Cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle there without mem_ready.
//    - If count==TIMEOUT-1 and no mem_ready: bus_error=1 for one cycle, next state FETCH.
//    - The cycle of a timeout from MEMWR performs no write. The counter restarts.
//    - mem_ready on that same cycle wins: no error.
// CONFIGURATION
//  Macro MC_JUMP_EN.
//  Defined: opcode 000010 in DECODE -> JUMP (11). JUMP drives PCWrite=1, PCSource=10 -> FETCH; 3 cycles.
//  Undefined: state 11 is absent; 000010 is illegal (illegal_op pulse, -> FETCH).
// STRUCTURE
//  Shared include mc_control_defs.vh:
//    - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
//    - state encodings S_FETCH..S_JUMP
//    - ALUOp / BranchOp / PCSource / ALUSrcB codes
//  Sub-module mem_wait_timer: clk, reset, clear, count_en, TIMEOUT -> expired.
//  The FSM, output decode and BranchOp latch stay in multicycle_control.
// TESTING
//  1. reset=1 for 2 cycles mid-MEMWR -> MemWrite=0 during reset; state=0 the cycle after release.
//  2. lw (100011), mem_ready tied 1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
//  3. R-type, mem_ready low 3 cycles in FETCH -> MemRead=1 held, IRWrite=0 until the ready cycle, then ALUWB with RegDst=1.
//  4. beq then bne -> BranchOp 01 then 10 in BRANCH, PCSource=01, ALUOp=01, 3 cycles each.
//  5. TIMEOUT=4, sw with mem_ready never high -> bus_error pulse on the 4th MEMWR cycle, next state FETCH.
//  6. opcode 111111 -> illegal_op pulse in DECODE; 000010 -> JUMP if MC_JUMP_EN, else illegal_op.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, state codes
// and the datapath select codes driven by multicycle_control.
package multicycle_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // States that hold a memory request open until mem_ready.
   function automatic logic is_wait_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the last allowed one.
// TIMEOUT of 0 disables expiry (wait forever).
module mem_wait_timer #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (count_en)
         cnt_d = cnt_q + TO_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   generate
      if (TIMEOUT == 0) begin : g_forever
         assign expired = 1'b0;
      end else begin : g_limit
         assign expired = (cnt_q == TO_W'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath with memory-ready stalls
// and timeout. Define MC_JUMP_EN to add the JUMP state for opcode 000010.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] BranchOp,
   output logic [1:0] PCSource,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       bus_error,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t     state_q, state_d;
   logic [1:0] br_q, br_d;
   logic       pending, expired, timeout, count_en, clear, illegal;

   // The counter only runs while a memory state is stalled; any move restarts it.
   assign pending  = is_wait_state(state_q) && !mem_ready;
   assign timeout  = pending && expired;
   assign count_en = pending && !expired;
   assign clear    = !count_en;

   mem_wait_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .count_en (count_en),
      .expired  (expired)
   );

   always_comb begin
      state_d = state_q;
      br_d    = br_q;
      illegal = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            br_d = (opcode == OP_BNE) ? BR_BNE : BR_BEQ;
            case (opcode)
               OP_RTYPE:        state_d = S_EXEC;
               OP_LW, OP_SW:    state_d = S_MEMADR;
               OP_BEQ, OP_BNE:  state_d = S_BRANCH;
               OP_ADDI:         state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
               OP_J:            state_d = S_JUMP;
`endif
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
      if (timeout)
         state_d = S_FETCH;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         br_q    <= BR_NONE;
      end else begin
         state_q <= state_d;
         br_q    <= br_d;
      end
   end

   always_comb begin
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      BranchOp   = BR_NONE;
      PCSource   = PCS_ALU;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REGB;
      ALUOp      = ALUOP_ADD;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      bus_error  = 1'b0;
      illegal_op = 1'b0;
      state      = 4'd0;
      if (!reset) begin
         state     = state_q;
         bus_error = timeout;
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: begin
               ALUSrcB    = SRCB_IMMSH;
               illegal_op = illegal;
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            // A timed-out write cycle must not reach memory.
            S_MEMWR: begin
               MemWrite = !timeout;
               IorD     = 1'b1;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA  = 1'b1;
               ALUOp    = ALUOP_SUB;
               PCSource = PCS_ALUOUT;
               BranchOp = br_q;
            end
            S_ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: RegWrite = 1'b1;
`ifdef MC_JUMP_EN
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = PCS_JUMP;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model plus directed
// scenarios and randomized opcode / mem_ready / reset traffic.
module tb_multicycle_control;

   localparam int TMO = 4;
   localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
   localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

   logic clk = 1'b0;
   logic reset = 1'b1, mem_ready = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic IorD, IRWrite, PCWrite, ALUSrcA, RegDst, MemtoReg, RegWrite;
   logic MemRead, MemWrite, bus_error, illegal_op;
   logic [1:0] BranchOp, PCSource, ALUSrcB, ALUOp;
   logic [3:0] state;

   multicycle_control #(.TIMEOUT(TMO), .TO_W(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .BranchOp(BranchOp),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .bus_error(bus_error),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   wire [22:0] dut_vec = {IorD, IRWrite, PCWrite, BranchOp, PCSource, ALUSrcA, ALUSrcB,
                          ALUOp, RegDst, MemtoReg, RegWrite, MemRead, MemWrite,
                          bus_error, illegal_op, state};

   int checks = 0, errors = 0;

   // Reference model: current step of the instruction, remaining steps, stall count.
   int m_st = 0, m_wait = 0;
   logic [1:0] m_br = 2'b00;
   int m_q[$];

   function automatic logic legal(input logic [5:0] op);
      bit j_ok;
`ifdef MC_JUMP_EN
      j_ok = 1'b1;
`else
      j_ok = 1'b0;
`endif
      return (op == RTYPE) || (op == LW) || (op == SW) || (op == BEQ) ||
             (op == BNE) || (op == ADDI) || (j_ok && op == JMP);
   endfunction

   function automatic logic waiting_step(input int s);
      return (s == 0) || (s == 3) || (s == 5);
   endfunction

   task automatic load_steps(input logic [5:0] op);
      m_q.delete();
      if (op == RTYPE) begin m_q.push_back(6); m_q.push_back(7); end
      else if (op == LW) begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
      else if (op == SW) begin m_q.push_back(2); m_q.push_back(5); end
      else if (op == BEQ || op == BNE) m_q.push_back(8);
      else if (op == ADDI) begin m_q.push_back(9); m_q.push_back(10); end
      else if (op == JMP && legal(op)) m_q.push_back(11);
   endtask

   function automatic logic [22:0] expect_vec(input logic rst, input logic [5:0] op,
                                              input logic rdy);
      logic iord, irw, pcw, srca, rdst, m2r, rw, mr, mw, be, ill, to;
      logic [1:0] bop, pcs, srcb, aop;
      logic [3:0] st;
      {iord, irw, pcw, srca, rdst, m2r, rw, mr, mw, be, ill} = '0;
      {bop, pcs, srcb, aop} = '0;
      st = 4'd0;
      to = waiting_step(m_st) && !rdy && (m_wait == TMO - 1);
      if (!rst) begin
         st = m_st[3:0];
         be = to;
         case (m_st)
            0:  begin mr = 1; srcb = 2'd1; irw = rdy; pcw = rdy; end
            1:  begin srcb = 2'd3; ill = !legal(op); end
            2:  begin srca = 1; srcb = 2'd2; end
            3:  begin mr = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mw = !to; iord = 1; end
            6:  begin srca = 1; aop = 2'd2; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; aop = 2'd1; pcs = 2'd1; bop = m_br; end
            9:  begin srca = 1; srcb = 2'd2; end
            10: rw = 1;
            11: begin pcw = 1; pcs = 2'd2; end
            default: ;
         endcase
      end
      return {iord, irw, pcw, bop, pcs, srca, srcb, aop, rdst, m2r, rw, mr, mw, be, ill, st};
   endfunction

   task automatic advance(input logic rst, input logic [5:0] op, input logic rdy);
      if (rst) begin
         m_st = 0; m_wait = 0; m_q.delete();
      end else if (waiting_step(m_st) && !rdy) begin
         if (m_wait == TMO - 1) begin
            m_st = 0; m_wait = 0; m_q.delete();
         end else begin
            m_wait++;
         end
      end else begin
         m_wait = 0;
         if (m_st == 1) begin
            if (op == BEQ) m_br = 2'b01;
            if (op == BNE) m_br = 2'b10;
            load_steps(op);
         end
         if (m_q.size() > 0) m_st = m_q.pop_front();
         else m_st = (m_st == 0) ? 1 : 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, compare every output against the model, step the model.
   task automatic cycle(input logic rst, input logic [5:0] op, input logic rdy);
      logic [22:0] e;
      @(negedge clk);
      reset = rst; opcode = op; mem_ready = rdy;
      #1;
      e = expect_vec(rst, op, rdy);
      chk("cycle_outputs", {9'd0, dut_vec}, {9'd0, e});
      advance(rst, op, rdy);
   endtask

   initial begin
      int lw_st[5];
      logic [5:0] rop;
      logic slow, rdy, rst;
      lw_st = '{0, 1, 2, 3, 4};

      cycle(1, RTYPE, 0);
      chk("reset_state", {28'd0, state}, 32'd0);
      chk("reset_memread", {31'd0, MemRead}, 32'd0);
      cycle(1, RTYPE, 1);

      for (int i = 0; i < 5; i++) begin
         cycle(0, LW, 1);
         chk("lw_state", {28'd0, state}, lw_st[i]);
         chk("lw_regwrite", {31'd0, RegWrite}, (i == 4) ? 32'd1 : 32'd0);
         chk("lw_memtoreg", {31'd0, MemtoReg}, (i == 4) ? 32'd1 : 32'd0);
      end

      for (int i = 0; i < 3; i++) begin
         cycle(0, RTYPE, 0);
         chk("rt_stall_memread", {31'd0, MemRead}, 32'd1);
         chk("rt_stall_irwrite", {31'd0, IRWrite}, 32'd0);
      end
      cycle(0, RTYPE, 1);
      chk("rt_ready_irwrite", {31'd0, IRWrite}, 32'd1);
      cycle(0, RTYPE, 0);
      cycle(0, RTYPE, 0);
      chk("rt_exec_aluop", {30'd0, ALUOp}, 32'd2);
      cycle(0, RTYPE, 0);
      chk("rt_aluwb_state", {28'd0, state}, 32'd7);
      chk("rt_aluwb_regdst", {31'd0, RegDst}, 32'd1);

      cycle(0, BEQ, 1); cycle(0, BEQ, 0); cycle(0, BEQ, 0);
      chk("beq_state", {28'd0, state}, 32'd8);
      chk("beq_branchop", {30'd0, BranchOp}, 32'd1);
      chk("beq_pcsource", {30'd0, PCSource}, 32'd1);
      chk("beq_aluop", {30'd0, ALUOp}, 32'd1);
      cycle(0, BNE, 1);
      chk("bne_fetch_after_3", {28'd0, state}, 32'd0);
      cycle(0, BNE, 0); cycle(0, BNE, 0);
      chk("bne_branchop", {30'd0, BranchOp}, 32'd2);

      cycle(0, SW, 1); cycle(0, SW, 0); cycle(0, SW, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, SW, 0);
         chk("sw_to_state", {28'd0, state}, 32'd5);
         chk("sw_to_buserr", {31'd0, bus_error}, (i == 3) ? 32'd1 : 32'd0);
         chk("sw_to_memwrite", {31'd0, MemWrite}, (i == 3) ? 32'd0 : 32'd1);
      end
      cycle(0, SW, 0);
      chk("sw_to_next_fetch", {28'd0, state}, 32'd0);

      cycle(0, SW, 1); cycle(0, SW, 0); cycle(0, SW, 0);
      cycle(0, SW, 0);
      chk("rst_mid_memwr_pre", {31'd0, MemWrite}, 32'd1);
      for (int i = 0; i < 2; i++) begin
         cycle(1, SW, 0);
         chk("rst_mid_memwrite", {31'd0, MemWrite}, 32'd0);
      end
      cycle(0, SW, 0);
      chk("rst_release_state", {28'd0, state}, 32'd0);

      cycle(0, BAD, 1); cycle(0, BAD, 0);
      chk("bad_illegal", {31'd0, illegal_op}, 32'd1);
      cycle(0, BAD, 0);
      chk("bad_back_fetch", {28'd0, state}, 32'd0);
      cycle(0, JMP, 1); cycle(0, JMP, 0);
`ifdef MC_JUMP_EN
      chk("j_not_illegal", {31'd0, illegal_op}, 32'd0);
      cycle(0, JMP, 0);
      chk("j_state", {28'd0, state}, 32'd11);
      chk("j_pcwrite", {31'd0, PCWrite}, 32'd1);
`else
      chk("j_illegal", {31'd0, illegal_op}, 32'd1);
      cycle(0, JMP, 0);
      chk("j_back_fetch", {28'd0, state}, 32'd0);
`endif

      rop = RTYPE;
      slow = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (m_st == 0) begin
            case ($urandom_range(0, 9))
               0: rop = RTYPE;
               1, 9: rop = LW;
               2: rop = SW;
               3: rop = BEQ;
               4: rop = BNE;
               5: rop = ADDI;
               6: rop = JMP;
               7: rop = BAD;
               default: rop = 6'($urandom_range(0, 63));
            endcase
         end
         if (m_st == 1) slow = ($urandom_range(0, 3) == 0);
         rdy = slow ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 199) == 0);
         cycle(rst, rop, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
